router_xy_buffered: RTL and testbench

// Clocked, parametrised 5-port NoC router for an X_DIM x Y_DIM mesh or torus.
// - Each input port has a FIFO_DEPTH-entry FIFO.
// - Each output port has a 1-entry register and a round-robin arbiter.
// - Routing is dimension-ordered (X first, then Y); in torus mode it takes the shortest direction.
// - One instance per mesh node, between neighbouring routers and the local PE/memory port.

---
 rtl/router_xy_buffered.sv | 178 +++++++++++++++++
 tb/tb_router_xy_buffered.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_xy_buffered.sv
// router_xy_buffered
// Five-port buffered NoC router (0=left 1=right 2=up 3=down 4=pe_mem).
// Each input has a small FIFO. Each output has a one-entry register and a
// round-robin arbiter. Routing is dimension-ordered, X first then Y. In
// torus mode the router takes the shorter way round, and a tie goes left
// or down.
module router_xy_buffered #(
  parameter int WIDTH_PACKAGE = 33,
  parameter int WIDTH_ADDR    = 4,
  parameter int X_DIM         = 4,
  parameter int Y_DIM         = 4,
  parameter int ROUTER_X      = 1,
  parameter int ROUTER_Y      = 1,
  parameter int FIFO_DEPTH    = 2,
  parameter int TORUS         = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [4:0]                 in_valid,
  input  logic [5*WIDTH_PACKAGE-1:0] in_data,
  output logic [4:0]                 in_ready,
  output logic [4:0]                 out_valid,
  output logic [5*WIDTH_PACKAGE-1:0] out_data,
  input  logic [4:0]                 out_ready,
  output logic                       err_unroutable
);

  localparam int NP = 5;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam int unsigned XD = X_DIM;
  localparam int unsigned YD = Y_DIM;
  localparam int unsigned RX = ROUTER_X;
  localparam int unsigned RY = ROUTER_Y;

  localparam logic [2:0] P_LEFT  = 3'd0;
  localparam logic [2:0] P_RIGHT = 3'd1;
  localparam logic [2:0] P_UP    = 3'd2;
  localparam logic [2:0] P_DOWN  = 3'd3;
  localparam logic [2:0] P_PE    = 3'd4;

  logic [WIDTH_PACKAGE-1:0] fifo_mem [NP][FIFO_DEPTH];
  logic [PW-1:0]            rd_ptr   [NP];
  logic [PW-1:0]            wr_ptr   [NP];
  logic [CW-1:0]            count    [NP];
  logic [2:0]               rr_ptr   [NP];

  logic [WIDTH_PACKAGE-1:0] head     [NP];
  logic [2:0]               head_dir [NP];
  logic [NP-1:0]            head_valid;
  logic [NP-1:0]            head_bad;
  logic [NP-1:0]            push;
  logic [NP-1:0]            pop;
  logic [NP-1:0]            grant;
  logic [2:0]               winner   [NP];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  function automatic logic is_unroutable(input logic [WIDTH_ADDR-1:0] id);
    return 32'(id) >= XD * YD;
  endfunction

  // Output port for a destination id. X is resolved fully before Y is considered.
  function automatic logic [2:0] route_dir(input logic [WIDTH_ADDR-1:0] id);
    int unsigned idv;
    int unsigned xv;
    int unsigned yv;
    int unsigned fwd;
    logic [2:0]  dir;
    idv = 32'(id);
    xv  = idv % XD;
    yv  = idv / XD;
    fwd = 0;
    dir = P_PE;
    if (xv != RX) begin
      fwd = (xv + XD - RX) % XD;
      if (TORUS != 0) dir = (fwd < XD - fwd) ? P_RIGHT : P_LEFT;
      else            dir = (xv > RX) ? P_RIGHT : P_LEFT;
    end else if (yv != RY) begin
      fwd = (yv + YD - RY) % YD;
      if (TORUS != 0) dir = (fwd < YD - fwd) ? P_UP : P_DOWN;
      else            dir = (yv > RY) ? P_UP : P_DOWN;
    end
    return dir;
  endfunction

  // Decode the head of each FIFO. in_ready depends on stored occupancy only.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      head[i]       = fifo_mem[i][rd_ptr[i]];
      head_valid[i] = (count[i] != '0);
      in_ready[i]   = (count[i] != CW'(FIFO_DEPTH));
      push[i]       = in_valid[i] && in_ready[i];
      head_bad[i]   = head_valid[i] &&
                      is_unroutable(head[i][WIDTH_PACKAGE-1 -: WIDTH_ADDR]);
      head_dir[i]   = route_dir(head[i][WIDTH_PACKAGE-1 -: WIDTH_ADDR]);
    end
  end

  // For each output, grant the first requester found at or after its pointer.
  // A grant is made only if the register is empty or drains this cycle.
  always_comb begin
    logic [2:0] cand;
    cand = '0;
    for (int o = 0; o < NP; o++) begin
      grant[o]  = 1'b0;
      winner[o] = '0;
      if (!out_valid[o] || out_ready[o]) begin
        for (int k = 0; k < NP; k++) begin
          cand = 3'((32'(rr_ptr[o]) + 32'(k)) % NP);
          if (!grant[o] && head_valid[cand] && !head_bad[cand] &&
              head_dir[cand] == 3'(o)) begin
            grant[o]  = 1'b1;
            winner[o] = cand;
          end
        end
      end
    end
  end

  // A head pops when it wins an output or when its destination cannot be routed.
  always_comb begin
    pop = head_bad;
    for (int o = 0; o < NP; o++) begin
      if (grant[o]) pop[winner[o]] = 1'b1;
    end
  end

  // FIFO storage. Stale entries are never read because the counts gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (push[i]) fifo_mem[i][wr_ptr[i]] <= in_data[i*WIDTH_PACKAGE +: WIDTH_PACKAGE];
    end
  end

  // FIFO pointers and occupancy. Reset flushes every queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NP; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (push[i]) wr_ptr[i] <= next_ptr(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= next_ptr(rd_ptr[i]);
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  // Output registers, arbiter pointers and the unroutable-drop pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= '0;
      out_data       <= '0;
      err_unroutable <= 1'b0;
      for (int o = 0; o < NP; o++) rr_ptr[o] <= '0;
    end else begin
      err_unroutable <= |head_bad;
      for (int o = 0; o < NP; o++) begin
        if (grant[o]) begin
          out_valid[o]                                   <= 1'b1;
          out_data[o*WIDTH_PACKAGE +: WIDTH_PACKAGE]     <= head[winner[o]];
          rr_ptr[o] <= (winner[o] == 3'd4) ? 3'd0 : winner[o] + 3'd1;
        end else if (out_ready[o]) begin
          out_valid[o] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_xy_buffered.sv
// tb_router_xy_buffered
// Self-checking bench with three router instances: torus 4x4, mesh 4x4 and
// torus 4x3. All of them sit at node (1,1). Packets carry dest[32:29],
// src[28:26], seq[25:10] and random fill bits.
module tb_router_xy_buffered;

  localparam int W = 33;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0]   in_valid,   in_ready,   out_valid,   out_ready;
  logic [5*W-1:0] in_data,  out_data;
  logic         err;
  logic [4:0]   in_valid_m, in_ready_m, out_valid_m, out_ready_m;
  logic [5*W-1:0] in_data_m, out_data_m;
  logic         err_m;
  logic [4:0]   in_valid_y, in_ready_y, out_valid_y, out_ready_y;
  logic [5*W-1:0] in_data_y, out_data_y;
  logic         err_y;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] expq [25][$];

  router_xy_buffered dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .err_unroutable(err));

  router_xy_buffered #(.TORUS(0)) dut_mesh (
    .clk(clk), .reset(reset), .in_valid(in_valid_m), .in_data(in_data_m),
    .in_ready(in_ready_m), .out_valid(out_valid_m), .out_data(out_data_m),
    .out_ready(out_ready_m), .err_unroutable(err_m));

  router_xy_buffered #(.Y_DIM(3)) dut_y3 (
    .clk(clk), .reset(reset), .in_valid(in_valid_y), .in_data(in_data_y),
    .in_ready(in_ready_y), .out_valid(out_valid_y), .out_data(out_data_y),
    .out_ready(out_ready_y), .err_unroutable(err_y));

  // Reference routing for node (1,1), based on distances: -1 means unroutable.
  function automatic int model_port(input int dest, input int xdim, input int ydim, input bit torus);
    int rx = 1;
    int ry = 1;
    int x, y, d_plus, d_minus;
    if (dest >= xdim * ydim) return -1;
    x = dest % xdim;
    y = dest / xdim;
    if (x != rx) begin
      if (!torus) return (x > rx) ? 1 : 0;
      d_plus  = (x - rx + xdim) % xdim;
      d_minus = (rx - x + xdim) % xdim;
      return (d_plus < d_minus) ? 1 : 0;
    end
    if (y != ry) begin
      if (!torus) return (y > ry) ? 2 : 3;
      d_plus  = (y - ry + ydim) % ydim;
      d_minus = (ry - y + ydim) % ydim;
      return (d_plus < d_minus) ? 2 : 3;
    end
    return 4;
  endfunction

  function automatic logic [W-1:0] mk_pkt(input int dest, input int src, input int seq);
    return {4'(dest), 3'(src), 16'(seq), 10'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    in_valid = '0; in_data = '0; out_ready = '1;
    in_valid_m = '0; in_data_m = '0; out_ready_m = '1;
    in_valid_y = '0; in_data_y = '0; out_ready_y = '1;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 5'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 00000", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (err !== 1'b0 || err_m !== 1'b0 || err_y !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b%b%b expected 000", err, err_m, err_y); end
    checks++; if (in_ready !== 5'b11111) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 11111", in_ready); end
    checks++; if (in_ready_m !== 5'b11111 || in_ready_y !== 5'b11111) begin errors++; $display("[TB] FAIL reset_in_ready_other: got %b %b expected 11111", in_ready_m, in_ready_y); end
    tick();
    checks++; if (in_ready !== 5'b11111 || out_valid !== 5'b0) begin errors++; $display("[TB] FAIL reset_idle: in_ready %b out_valid %b expected 11111 00000", in_ready, out_valid); end
  endtask

  task automatic test_latency();
    do_reset();
    in_data[0 +: W] = 33'h0A0000001;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    checks++; if (out_valid !== 5'b0) begin errors++; $display("[TB] FAIL latency_early: got %b expected 00000", out_valid); end
    tick();
    checks++; if (out_valid !== 5'b10000) begin errors++; $display("[TB] FAIL latency_valid: got %b expected 10000", out_valid); end
    checks++; if (out_data[4*W +: W] !== 33'h0A0000001) begin errors++; $display("[TB] FAIL latency_data: got %h expected 0a0000001", out_data[4*W +: W]); end
    tick();
    checks++; if (out_valid !== 5'b0) begin errors++; $display("[TB] FAIL latency_drain: got %b expected 00000", out_valid); end
  endtask

  task automatic test_routing();
    logic [W-1:0] pkt;
    int pt, pm;
    do_reset();
    for (int d = 0; d < 16; d++) begin
      pkt = mk_pkt(d, 4, d);
      in_data[4*W +: W] = pkt;   in_valid[4] = 1'b1;
      in_data_m[4*W +: W] = pkt; in_valid_m[4] = 1'b1;
      tick();
      in_valid[4] = 1'b0; in_valid_m[4] = 1'b0;
      tick();
      pt = model_port(d, 4, 4, 1'b1);
      pm = model_port(d, 4, 4, 1'b0);
      checks++; if (out_valid !== 5'(1 << pt)) begin errors++; $display("[TB] FAIL route_torus dest %0d: got %b expected %b", d, out_valid, 5'(1 << pt)); end
      checks++; if (out_valid_m !== 5'(1 << pm)) begin errors++; $display("[TB] FAIL route_mesh dest %0d: got %b expected %b", d, out_valid_m, 5'(1 << pm)); end
      checks++; if (out_data[pt*W +: W] !== pkt) begin errors++; $display("[TB] FAIL route_data dest %0d: got %h expected %h", d, out_data[pt*W +: W], pkt); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] d;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_data[i*W +: W] = mk_pkt(5, i, 0);
      in_valid[i] = 1'b1;
    end
    tick();
    tick();
    for (int n = 0; n < 6; n++) begin
      d = out_data[4*W +: W];
      checks++; if (out_valid[4] !== 1'b1 || d[28:26] !== 3'(n % 3)) begin errors++; $display("[TB] FAIL rr_order step %0d: got valid %b src %0d expected valid 1 src %0d", n, out_valid[4], d[28:26], n % 3); end
      tick();
    end
    in_valid = '0;
    for (int c = 0; c < 10; c++) tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] pkts [4];
    logic [W-1:0] got [$];
    int accepted;
    bit acc_now;
    do_reset();
    for (int k = 0; k < 4; k++) pkts[k] = mk_pkt(5, 0, 100 + k);
    out_ready[4] = 1'b0;
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid[4]) begin
        checks++; if (out_data[4*W +: W] !== pkts[0]) begin errors++; $display("[TB] FAIL bp_stable cycle %0d: got %h expected %h", c, out_data[4*W +: W], pkts[0]); end
      end
      in_valid[0] = (accepted < 4);
      if (accepted < 4) in_data[0 +: W] = pkts[accepted];
      acc_now = in_valid[0] && in_ready[0];
      tick();
      if (acc_now) accepted++;
    end
    checks++; if (accepted != 3) begin errors++; $display("[TB] FAIL bp_accepted: got %0d expected 3", accepted); end
    checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: got %b expected 0", in_ready[0]); end
    out_ready[4] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid[4] && out_ready[4]) got.push_back(out_data[4*W +: W]);
      in_valid[0] = (accepted < 4);
      if (accepted < 4) in_data[0 +: W] = pkts[accepted];
      acc_now = in_valid[0] && in_ready[0];
      tick();
      if (acc_now) accepted++;
    end
    checks++; if (got.size() != 4) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 4", got.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= got.size()) begin errors++; $display("[TB] FAIL bp_order %0d: got none expected %h", k, pkts[k]); end
      else if (got[k] !== pkts[k]) begin errors++; $display("[TB] FAIL bp_order %0d: got %h expected %h", k, got[k], pkts[k]); end
    end
  endtask

  task automatic test_unroutable();
    int pulses, first, p;
    bit any_valid;
    logic [W-1:0] pkt;
    do_reset();
    in_data_y[0 +: W] = mk_pkt(12, 0, 0);
    in_valid_y[0] = 1'b1;
    tick();
    in_valid_y[0] = 1'b0;
    pulses = 0; first = -1; any_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (err_y) begin pulses++; if (first < 0) first = c; end
      if (out_valid_y !== 5'b0) any_valid = 1'b1;
      tick();
    end
    checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL unroutable_pulses: got %0d expected 1", pulses); end
    checks++; if (first != 1) begin errors++; $display("[TB] FAIL unroutable_timing: got cycle %0d expected 1", first); end
    checks++; if (any_valid) begin errors++; $display("[TB] FAIL unroutable_output: got 1 expected 0"); end
    checks++; if (in_ready_y !== 5'b11111) begin errors++; $display("[TB] FAIL unroutable_drain: got %b expected 11111", in_ready_y); end
    pkt = mk_pkt(4, 0, 1);
    p = model_port(4, 4, 3, 1'b1);
    in_data_y[0 +: W] = pkt;
    in_valid_y[0] = 1'b1;
    tick();
    in_valid_y[0] = 1'b0;
    tick();
    checks++; if (out_valid_y !== 5'(1 << p) || out_data_y[p*W +: W] !== pkt) begin errors++; $display("[TB] FAIL y3_route: got %b %h expected %b %h", out_valid_y, out_data_y[p*W +: W], 5'(1 << p), pkt); end
    tick();
  endtask

  task automatic test_reset_midflight();
    bit stale;
    do_reset();
    out_ready = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 5; i++) in_data[i*W +: W] = mk_pkt($urandom_range(0, 15), i, c);
      in_valid = '1;
      tick();
    end
    in_valid = '0;
    reset = 1'b1;
    tick();
    checks++; if (out_valid !== 5'b0) begin errors++; $display("[TB] FAIL midreset_out_valid: got %b expected 00000", out_valid); end
    checks++; if (in_ready !== 5'b11111) begin errors++; $display("[TB] FAIL midreset_in_ready: got %b expected 11111", in_ready); end
    reset = 1'b0;
    out_ready = '1;
    stale = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid !== 5'b0 || err !== 1'b0) stale = 1'b1;
      tick();
    end
    checks++; if (stale) begin errors++; $display("[TB] FAIL midreset_stale: got 1 expected 0"); end
  endtask

  task automatic check_deliveries();
    logic [W-1:0] d;
    int k;
    for (int o = 0; o < 5; o++) begin
      if (out_valid[o] && out_ready[o]) begin
        d = out_data[o*W +: W];
        k = int'(d[28:26]) * 5 + o;
        checks++;
        if (d[28:26] > 3'd4 || expq[k].size() == 0 || expq[k][0] !== d) begin
          errors++;
          $display("[TB] FAIL rand_delivery port %0d: got %h expected an in-order packet from src %0d", o, d, d[28:26]);
        end else begin
          void'(expq[k].pop_front());
        end
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] pkt;
    int seq, dest, left;
    bit err_seen;
    do_reset();
    for (int k = 0; k < 25; k++) expq[k].delete();
    seq = 0; err_seen = 1'b0;
    for (int c = 0; c < 600; c++) begin
      out_ready = 5'($urandom);
      check_deliveries();
      for (int i = 0; i < 5; i++) begin
        in_valid[i] = 1'($urandom);
        if (in_valid[i]) begin
          dest = $urandom_range(0, 15);
          pkt = mk_pkt(dest, i, seq);
          seq++;
          in_data[i*W +: W] = pkt;
          if (in_ready[i]) expq[i*5 + model_port(dest, 4, 4, 1'b1)].push_back(pkt);
        end
      end
      if (err) err_seen = 1'b1;
      tick();
    end
    in_valid = '0;
    out_ready = '1;
    for (int c = 0; c < 60; c++) begin
      check_deliveries();
      tick();
    end
    left = 0;
    for (int k = 0; k < 25; k++) left += expq[k].size();
    checks++; if (left != 0) begin errors++; $display("[TB] FAIL rand_leftover: got %0d undelivered expected 0", left); end
    checks++; if (err_seen) begin errors++; $display("[TB] FAIL rand_err: got 1 expected 0"); end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    idle_all();
    reset = 1'b1;
    test_reset();
    test_latency();
    test_routing();
    test_round_robin();
    test_backpressure();
    test_unroutable();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
